z_buffer_mem: RTL
=================

Name: z_buffer_mem

Overview:
- Responder end of the depth-buffer memory interface: holds X_RES*Y_RES depth words on chip.
- Serves the read/write handshakes issued by the rasteriser's depth-test block.
- Self-initialises every entry to the far value (all ones) after reset, and on a clear_i request.
- Reports out-of-range accesses through a sticky error flag.

Parameters:
- Z_SIZE, 8, depth word width.
- X_RES, 4, horizontal resolution.
- Y_RES, 4, vertical resolution.
- DEPTH, X_RES*Y_RES, number of entries.
- ADDR_SIZE, 32, address width.
- BASE_ADDR, 0, address of entry 0.
- READ_LAT, 1, read access latency in cycles; legal range 1..4.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- buf_r_w  in  1  1 = read, 0 = write.
- buf_addr  in  ADDR_SIZE  access address.
- buf_data_w  in  Z_SIZE  write data.
- buf_data_r  out  Z_SIZE  read data.
- data_r_ready  in  1  read request / response acceptance.
- data_r_valid  out  1  read data valid.
- data_w_valid  in  1  write request valid.
- data_w_ready  out  1  write accepted.
- clear_i  in  1  single-cycle pulse: set all entries to all ones.
- busy_o  out  1  init/clear sweep in progress.
- addr_err_o  out  1  sticky out-of-range access flag.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - Outputs: data_r_valid=0, buf_data_r=0, data_w_ready=0, addr_err_o=0, busy_o=1.
  - State goes to INIT with sweep counter 0.
  - Array contents are not reset; the INIT sweep rewrites them.
- States: INIT, IDLE, RD_WAIT, RD_RESP, WR_ACK.
- INIT:
  - Writes all ones to entry cnt each cycle; cnt increments 0..DEPTH-1.
  - After entry DEPTH-1 is written, goes to IDLE and busy_o drops. busy_o is high for exactly DEPTH cycles.
  - No handshakes accepted in INIT: data_w_ready=0, data_r_valid=0.
- Decode:
  - in_range = (buf_addr >= BASE_ADDR) && (buf_addr - BASE_ADDR < DEPTH).
  - Index = low $clog2(DEPTH) bits of (buf_addr - BASE_ADDR).
- IDLE priority: clear_i > write > read.
  - clear_i=1: addr_err_o cleared, cnt=0, go to INIT.
  - buf_r_w=0 && data_w_valid=1: go to WR_ACK.
  - buf_r_w=1 && data_r_ready=1: capture index and in_range; go to RD_WAIT if READ_LAT>1, otherwise RD_RESP.
- Read path:
  - RD_WAIT counts READ_LAT-1 cycles, then goes to RD_RESP.
  - data_r_valid rises exactly READ_LAT cycles after the request was sampled in IDLE.
  - buf_data_r = stored word, or all ones if out of range; out-of-range also sets addr_err_o.
  - In RD_RESP, data_r_valid and buf_data_r are held stable until data_r_valid && data_r_ready.
  - After the handshake: data_r_valid=0 next cycle, return to IDLE.
  - A read request still present in IDLE starts a new read.
- Write path:
  - WR_ACK asserts data_w_ready for one cycle.
  - The write commits on that edge if data_w_valid=1, using buf_addr and buf_data_w as presented at the handshake.
  - Out-of-range: the write is dropped, the handshake still completes, addr_err_o is set.
  - If data_w_valid fell before WR_ACK, nothing is written.
  - Returns to IDLE either way; a held data_w_valid gives one accepted write every 2 cycles.
- clear_i:
  - Honoured only in IDLE.
  - Pulses during INIT are ignored.
  - Pulses during a read/write transaction are ignored; the initiator retries after the handshake.
- Ordering: read-after-write returns the new data, since the write commits before IDLE can accept a read.
- Reset mid-transaction: data_r_valid and data_w_ready drop immediately; a pending write not yet at its handshake edge is lost.

Test Plan:
- Reset release -> busy_o high exactly 16 cycles; then read addr 5 -> buf_data_r=0xFF, data_r_valid 1 cycle after request.
- Write addr 3 data 0x42, then read addr 3 -> 0x42; READ_LAT=3 build -> data_r_valid 3 cycles after the request sample.
- Hold data_w_valid high with address incrementing 0..15 on each handshake, data 0x10+i -> 16 handshakes at one per 2 cycles; readback of every entry matches.
- Read addr 16 -> 0xFF and addr_err_o=1; write 0x00 to addr 20 -> handshake completes, no entry changes; clear_i -> addr_err_o=0.
- Write 0x07 to addr 9, pulse clear_i -> busy_o high 16 cycles; read addr 9 -> 0xFF; clear_i during a read is ignored.
- Hold data_r_ready low in RD_RESP for 5 cycles -> data_r_valid and data stay stable; rst_ni low mid-read -> data_r_valid=0 at once, busy_o=1.

Source files
------------

// File: rtl/z_buffer_mem.sv
// On-chip depth buffer answering the depth-test block's read/write handshakes.
// Every entry is swept to the far value (all ones) after reset and on clear_i.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_INIT    | sweep writes all ones to entry cnt, busy_o high
// S_IDLE    | waiting for clear, write or read request (in that priority)
// S_RD_WAIT | read latency down-counter running
// S_RD_RESP | data_r_valid high, holding data until data_r_ready
// S_WR_ACK  | data_w_ready high for one cycle; write commits on this edge
module z_buffer_mem #(
  parameter int                   Z_SIZE    = 8,
  parameter int                   X_RES     = 4,
  parameter int                   Y_RES     = 4,
  parameter int                   DEPTH     = X_RES * Y_RES,
  parameter int                   ADDR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0,
  parameter int                   READ_LAT  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 buf_r_w,
  input  logic [ADDR_SIZE-1:0] buf_addr,
  input  logic [Z_SIZE-1:0]    buf_data_w,
  output logic [Z_SIZE-1:0]    buf_data_r,
  input  logic                 data_r_ready,
  output logic                 data_r_valid,
  input  logic                 data_w_valid,
  output logic                 data_w_ready,
  input  logic                 clear_i,
  output logic                 busy_o,
  output logic                 addr_err_o
);

  localparam int                   IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_SIZE-1:0] DEPTH_A   = ADDR_SIZE'(DEPTH);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [1:0]           WAIT_LOAD = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_RD_RESP = 3'd3;
  localparam logic [2:0] S_WR_ACK  = 3'd4;

  logic [2:0]           state;
  logic [IDX_W-1:0]     cnt;
  logic [IDX_W-1:0]     rd_idx;
  logic                 rd_ok;
  logic [1:0]           wait_cnt;
  logic                 rvalid_q;
  logic [Z_SIZE-1:0]    rdata_q;
  logic                 err_q;

  logic [Z_SIZE-1:0]    mem [DEPTH];

  logic [ADDR_SIZE-1:0] addr_off;
  logic                 in_range;
  logic [IDX_W-1:0]     cur_idx;
  logic [IDX_W-1:0]     rd_sel_idx;
  logic                 rd_sel_ok;
  logic [Z_SIZE-1:0]    rd_word;
  logic                 mem_we;
  logic [IDX_W-1:0]     mem_wa;
  logic [Z_SIZE-1:0]    mem_wd;

  always_comb begin
    addr_off = buf_addr - BASE_ADDR;
    in_range = (buf_addr >= BASE_ADDR) && (addr_off < DEPTH_A);
    cur_idx  = addr_off[IDX_W-1:0];
  end

  // Single-cycle reads come straight from the live address; longer ones use the capture.
  always_comb begin
    rd_sel_idx = (state == S_IDLE) ? cur_idx  : rd_idx;
    rd_sel_ok  = (state == S_IDLE) ? in_range : rd_ok;
    rd_word    = rd_sel_ok ? mem[rd_sel_idx] : '1;
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = cur_idx;
    mem_wd = buf_data_w;
    if (state == S_INIT) begin
      mem_we = 1'b1;
      mem_wa = cnt;
      mem_wd = '1;
    end else if (state == S_WR_ACK) begin
      mem_we = data_w_valid && in_range;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_INIT;
      cnt      <= '0;
      rd_idx   <= '0;
      rd_ok    <= 1'b0;
      wait_cnt <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IDX) state <= S_IDLE;
        end
        S_IDLE: begin
          if (clear_i) begin
            err_q <= 1'b0;
            cnt   <= '0;
            state <= S_INIT;
          end else if (!buf_r_w && data_w_valid) begin
            state <= S_WR_ACK;
          end else if (buf_r_w && data_r_ready) begin
            rd_idx <= cur_idx;
            rd_ok  <= in_range;
            if (READ_LAT > 1) begin
              wait_cnt <= WAIT_LOAD;
              state    <= S_RD_WAIT;
            end else begin
              rvalid_q <= 1'b1;
              rdata_q  <= rd_word;
              if (!rd_sel_ok) err_q <= 1'b1;
              state    <= S_RD_RESP;
            end
          end
        end
        S_RD_WAIT: begin
          if (wait_cnt == 2'd0) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
            if (!rd_sel_ok) err_q <= 1'b1;
            state    <= S_RD_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_RD_RESP: begin
          if (data_r_ready) begin
            rvalid_q <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_WR_ACK: begin
          if (data_w_valid && !in_range) err_q <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_INIT;
        end
      endcase
    end
  end

  assign buf_data_r   = rdata_q;
  assign data_r_valid = rvalid_q;
  assign data_w_ready = (state == S_WR_ACK);
  assign busy_o       = (state == S_INIT);
  assign addr_err_o   = err_q;

endmodule
